// File: rtl/wind_nmea_pkg.sv
// wind_nmea_pkg: shared states, sentence constants and ASCII helpers for the MWV scheduler
package wind_nmea_pkg;
  localparam int SENTENCE_LEN = 25;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] TRIGGER = 3'd1;
  localparam logic [2:0] WAIT_MEAS = 3'd2;
  localparam logic [2:0] CONVERT = 3'd3;
  localparam logic [2:0] SEND = 3'd4;
  localparam logic [2:0] DONE = 3'd5;
  localparam logic [2:0] WAIT_TICK = 3'd6;
  localparam logic [103:0] HEAD = "$WIMWV,000,R,";
  localparam logic [23:0] MID = ",N,";
  localparam logic [7:0] CH_A = "A";
  localparam logic [7:0] CH_V = "V";
  localparam logic [7:0] CH_STAR = "*";
  localparam logic [7:0] CH_ZERO = "0";
  localparam logic [7:0] CH_CR = 8'h0d;
  localparam logic [7:0] CH_LF = 8'h0a;
  function automatic logic [7:0] xor_fold(input logic [103:0] v);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 13; i++) r ^= v[8*i +: 8];
    return r;
  endfunction
  localparam logic [7:0] CSUM_FIXED = xor_fold({HEAD[95:0], 8'h00}) ^ xor_fold({80'd0, MID});
  function automatic logic [7:0] hex_nibble_to_ascii(input logic [3:0] n);
    return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction
endpackage

// File: rtl/bin2bcd8.sv
// bin2bcd8: 8-step sequential double-dabble, 8-bit binary to three BCD digits
module bin2bcd8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       done,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones
);
  logic [19:0] sr;
  logic [3:0] cnt;
  function automatic logic [19:0] dabble(input logic [19:0] s);
    logic [19:0] t;
    t = s;
    for (int i = 0; i < 3; i++) if (t[8+4*i +: 4] >= 4'd5) t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
    return {t[18:0], 1'b0};
  endfunction
  assign done = cnt == 4'd8;
  assign {hundreds, tens, ones} = sr[19:8];
  // the load performs the first shift so eight edges finish the conversion
  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
      cnt <= '0;
    end else if (start) begin
      sr <= dabble({12'd0, bin});
      cnt <= 4'd1;
    end else if (cnt != 4'd0 && cnt != 4'd8) begin
      sr <= dabble(sr);
      cnt <= cnt + 4'd1;
    end
  end
endmodule

// File: rtl/wind_nmea_scheduler.sv
// wind_nmea_scheduler: triggers wind measurements and streams MWV sentences to the UART
module wind_nmea_scheduler
  import wind_nmea_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int PERIOD_MS = 1000,
  parameter int TIMEOUT_MS = 1500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       continuous,
  input  logic       start,
  output logic       meas_start,
  input  logic       meas_valid,
  input  logic [7:0] meas_data,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic [7:0] last_speed,
  output logic       timeout_err
);
  localparam int DIV = CLK_FREQ_HZ / 1000;
  localparam int CAP = PERIOD_MS > TIMEOUT_MS ? PERIOD_MS : TIMEOUT_MS;
  localparam int DW = $clog2(DIV + 1);
  localparam int MW = $clog2(CAP + 1);
  logic [2:0] state, state_nxt;
  logic [DW-1:0] div_cnt, div_b;
  logic [MW-1:0] ms_cnt, ms_b, ms_nxt;
  logic tick, timed_out, period_hit, fire, ok, bcd_done;
  logic [4:0] idx;
  logic [3:0] d2, d1, d0;
  logic [7:0] status, csum;
  logic [8*SENTENCE_LEN-1:0] sentence;
  assign meas_start = state == TRIGGER;
  assign tx_valid = state == SEND;
  assign busy = state != IDLE && state != WAIT_TICK;
  assign fire = state == WAIT_MEAS && (meas_valid || timed_out);
  bin2bcd8 u_bcd (
    .clk(clk), .reset(reset), .start(fire), .bin(meas_valid ? meas_data : 8'd0),
    .done(bcd_done), .hundreds(d2), .tens(d1), .ones(d0)
  );
  // ms counter restarts in TRIGGER with that cycle already counted, so trigger-to-trigger is exact
  always_comb begin
    div_b = state == TRIGGER ? '0 : div_cnt;
    ms_b = state == TRIGGER ? '0 : ms_cnt;
    tick = div_b == DW'(DIV - 1);
    ms_nxt = ms_b + MW'(tick && ms_b < MW'(CAP));
    timed_out = ms_nxt >= MW'(TIMEOUT_MS);
    period_hit = ms_nxt >= MW'(PERIOD_MS);
  end
  // sentence image; checksum folds the fixed bytes into a constant and adds digits and status
  always_comb begin
    status = ok ? CH_A : CH_V;
    csum = CSUM_FIXED ^ (CH_ZERO | {4'h0, d2}) ^ (CH_ZERO | {4'h0, d1}) ^ (CH_ZERO | {4'h0, d0}) ^ status;
    sentence = {HEAD, CH_ZERO | {4'h0, d2}, CH_ZERO | {4'h0, d1}, CH_ZERO | {4'h0, d0}, MID, status,
                CH_STAR, hex_nibble_to_ascii(csum[7:4]), hex_nibble_to_ascii(csum[3:0]), CH_CR, CH_LF};
    tx_data = tx_valid ? sentence[8*(SENTENCE_LEN-1-int'(idx)) +: 8] : 8'h00;
  end
  // next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = start && enable ? TRIGGER : IDLE;
      TRIGGER: state_nxt = WAIT_MEAS;
      WAIT_MEAS: state_nxt = fire ? CONVERT : WAIT_MEAS;
      CONVERT: state_nxt = bcd_done ? SEND : CONVERT;
      SEND: state_nxt = tx_ready && idx == 5'(SENTENCE_LEN - 1) ? DONE : SEND;
      DONE: state_nxt = !(enable && continuous) ? IDLE : period_hit ? TRIGGER : WAIT_TICK;
      WAIT_TICK: state_nxt = !enable ? IDLE : period_hit ? TRIGGER : WAIT_TICK;
      default: state_nxt = IDLE;
    endcase
  end
  // state, counters, byte index and measurement capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      div_cnt <= '0;
      ms_cnt <= '0;
      idx <= '0;
      ok <= 1'b0;
      last_speed <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      div_cnt <= tick ? '0 : div_b + DW'(1);
      ms_cnt <= ms_nxt;
      idx <= state == SEND ? idx + 5'(tx_ready) : '0;
      if (state == IDLE && start && enable) timeout_err <= 1'b0;
      if (fire) begin
        ok <= meas_valid;
        last_speed <= meas_valid ? meas_data : 8'd0;
        if (!meas_valid) timeout_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_wind_nmea_scheduler.sv
// tb_wind_nmea_scheduler: directed checks of triggering, formatting, handshake and timing
module tb_wind_nmea_scheduler;
  logic clk = 0, reset = 1, enable = 0, continuous = 0, start = 0, meas_valid = 0, tx_ready = 0;
  logic [7:0] meas_data = 0;
  logic meas_start, tx_valid, busy, timeout_err;
  logic [7:0] tx_data, last_speed;
  int checks = 0, failures = 0, cyc = 0;
  wind_nmea_scheduler #(.CLK_FREQ_HZ(1000), .PERIOD_MS(40), .TIMEOUT_MS(10)) dut (
    .clk(clk), .reset(reset), .enable(enable), .continuous(continuous), .start(start),
    .meas_start(meas_start), .meas_valid(meas_valid), .meas_data(meas_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .last_speed(last_speed), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic start_pulse(input string tag);
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    check({tag, "_trig"}, meas_start, 1);
  endtask
  task automatic collect(input string exp, input bit rnd, input int drop_at, input int stop_at, input string tag);
    int n = 0, w = 0;
    bit stalled = 0;
    logic [7:0] held = 0;
    while (n < stop_at && w < 500) begin
      if (n == drop_at) enable = 0;
      if (tx_valid) begin
        if (stalled) check($sformatf("%s_hold%0d", tag, n), tx_data, held);
        else check($sformatf("%s_b%0d", tag, n), tx_data, exp[n]);
        tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        stalled = !tx_ready;
        held = tx_data;
        if (tx_ready) n++;
      end else tx_ready = 0;
      @(negedge clk);
      w++;
    end
    tx_ready = 0;
    check({tag, "_count"}, n, stop_at);
  endtask
  initial begin
    int lat, prev, w, cnt;
    string s123, s000v, s255, s077, s009;
    s123 = "$WIMWV,000,R,123,N,A*23\015\012";
    s000v = "$WIMWV,000,R,000,N,V*34\015\012";
    s255 = "$WIMWV,000,R,255,N,A*21\015\012";
    s077 = "$WIMWV,000,R,077,N,A*23\015\012";
    s009 = "$WIMWV,000,R,009,N,A*2A\015\012";
    repeat (3) @(negedge clk);
    reset = 0;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_meas_start", meas_start, 0);
    check("rst_busy", busy, 0);
    check("rst_last_speed", last_speed, 0);
    check("rst_timeout_err", timeout_err, 0);
    enable = 1;
    start_pulse("t1");
    check("t1_busy", busy, 1);
    repeat (3) @(negedge clk);
    meas_data = 123;
    meas_valid = 1;
    @(negedge clk) meas_valid = 0;
    lat = 1;
    while (!tx_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("t1_latency", lat, 9);
    collect(s123, 0, -1, 25, "t1");
    check("t1_no_extra", tx_valid, 0);
    check("t1_speed", last_speed, 123);
    check("t1_err", timeout_err, 0);
    @(negedge clk) check("t1_idle", busy, 0);
    start_pulse("t2");
    repeat (9) @(negedge clk);
    check("t2_err_early", timeout_err, 0);
    @(negedge clk) check("t2_err_set", timeout_err, 1);
    collect(s000v, 0, -1, 25, "t2");
    check("t2_speed", last_speed, 0);
    check("t2_err_sticky", timeout_err, 1);
    @(negedge clk);
    start_pulse("t3");
    check("t3_err_clr", timeout_err, 0);
    @(negedge clk);
    meas_data = 255;
    meas_valid = 1;
    @(negedge clk) meas_valid = 0;
    collect(s255, 1, -1, 25, "t3");
    check("t3_no_extra", tx_valid, 0);
    check("t3_speed", last_speed, 255);
    @(negedge clk);
    start_pulse("t7");
    repeat (9) @(negedge clk);
    meas_data = 77;
    meas_valid = 1;
    @(negedge clk) meas_valid = 0;
    collect(s077, 0, -1, 25, "t7");
    check("t7_err", timeout_err, 0);
    check("t7_speed", last_speed, 77);
    @(negedge clk);
    continuous = 1;
    start_pulse("t4");
    prev = 0;
    for (int p = 0; p < 6; p++) begin
      w = 0;
      while (!meas_start && w < 100) begin
        @(negedge clk);
        w++;
      end
      check($sformatf("t4_seen%0d", p), meas_start, 1);
      if (p > 0) check($sformatf("t4_period%0d", p), cyc - prev, 40);
      prev = cyc;
      @(negedge clk);
      check($sformatf("t4_pulse%0d", p), meas_start, 0);
      if (p == 1) start = 1;
      @(negedge clk) start = 0;
      meas_data = 9;
      meas_valid = 1;
      @(negedge clk) meas_valid = 0;
      collect(s009, 0, p == 5 ? 10 : -1, 25, $sformatf("t4_%0d", p));
    end
    @(negedge clk);
    check("t5_busy", busy, 0);
    cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (meas_start) cnt++;
    end
    check("t5_no_trigger", cnt, 0);
    check("t5_tx_valid", tx_valid, 0);
    enable = 1;
    continuous = 0;
    start_pulse("t6");
    collect(s000v, 0, -1, 12, "t6");
    check("t6_pre_valid", tx_valid, 1);
    check("t6_pre_err", timeout_err, 1);
    reset = 1;
    @(negedge clk);
    check("t6_tx_valid", tx_valid, 0);
    check("t6_meas_start", meas_start, 0);
    check("t6_busy", busy, 0);
    check("t6_err", timeout_err, 0);
    check("t6_speed", last_speed, 0);
    reset = 0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
